// File: rtl/coherence_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_ctrl_pkg
// Description : Shared types for the two-core coherence bus controller:
//               RAM word, RAM handshake state and bus FSM state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package coherence_bus_ctrl_pkg;

  typedef logic [31:0] word_t;

  // RAM handshake reported by the memory model
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,  // word completes this cycle
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    C2C   = 3'd2,
    RAM_D = 3'd3,
    RAM_I = 3'd4
  } bus_state_t;

  localparam int unsigned NUM_CORES = 2;

  // Word 0 of a 2-word block (address bit 2 selects the word)
  function automatic logic block_first(input word_t addr);
    return (addr[2] == 1'b0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/coherence_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_ctrl_if
// Description : Cache, snoop and RAM signals of the coherence bus.
//               master : the bus controller
//               slave  : the caches plus RAM model facing the controller
// Ports       : iREN/iaddr/iwait/iload        icache side (2 cores)
//               dREN/dWEN/daddr/dstore/dwait/dload  dcache side (2 cores)
//               ccwrite/cctrans/ccwait/ccinv/ccsnoopaddr  snoop handshake
//               ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  RAM port
//               bus_err                        sticky timeout flag
// Revision    : 1.0  initial release
// ============================================================================
interface coherence_bus_ctrl_if;
  import coherence_bus_ctrl_pkg::*;

  logic      [1:0] iREN;
  word_t     [1:0] iaddr;
  logic      [1:0] iwait;
  word_t     [1:0] iload;

  logic      [1:0] dREN;
  logic      [1:0] dWEN;
  word_t     [1:0] daddr;
  word_t     [1:0] dstore;
  logic      [1:0] dwait;
  word_t     [1:0] dload;

  logic      [1:0] ccwrite;
  logic      [1:0] cctrans;
  logic      [1:0] ccwait;
  logic      [1:0] ccinv;
  word_t     [1:0] ccsnoopaddr;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  ramstate_t       ramstate;

  logic            bus_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans,
           ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans,
           ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
           ramREN, ramWEN, ramaddr, ramstore, bus_err
  );

endinterface
`default_nettype wire

// File: rtl/coherence_bus_ctrl_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_ctrl_rr_arbiter2
// Description : Two-requester round-robin arbiter. The pointer names the
//               preferred core; on advance_i it moves to the core that was
//               not just served.
// Ports       : clk, rst      clock, async active-high reset
//               req_i         request per core
//               advance_i     a grant to done_id_i completed this cycle
//               done_id_i     core whose grant completed
//               gnt_id_o      core that wins now
//               gnt_vld_o     at least one request present
// Revision    : 1.0  initial release
// ============================================================================
module coherence_bus_ctrl_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       done_id_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_vld_o = |req_i;
    gnt_id_o  = ptr_q;
    if (!req_i[ptr_q]) begin
      gnt_id_o = ~ptr_q;
    end
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~done_id_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coherence_bus_ctrl
// Description : Shares one RAM port between two cores (dcache + icache each).
//               One word access in flight at a time. Dcache fills of block
//               word 0 snoop the peer dcache first; a dirty peer supplies both
//               words cache-to-cache while they are written back to RAM.
// Parameters  : TIMEOUT_CYC  RAM cycles before the sticky bus_err sets
// Ports       : clk, rst     clock, async active-high reset
//               bus          coherence_bus_ctrl_if.master (caches, snoop, RAM)
// Revision    : 1.0  initial release
// ============================================================================
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  coherence_bus_ctrl_if.master bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  bus_state_t       state_q, state_d;
  logic             g_q, g_d;          // granted core
  logic             word_q, word_d;    // C2C word index within the block
  logic [CNT_W-1:0] cnt_q, cnt_d;      // RAM cycles of the current access
  logic             bus_err_q, bus_err_d;

  logic peer;
  logic acc;
  logic ram_phase;

  logic d_gnt, d_vld, d_adv;
  logic i_gnt, i_vld, i_adv;

  assign peer      = ~g_q;
  assign acc       = (bus.ramstate == ACCESS);
  assign ram_phase = (state_q == C2C) || (state_q == RAM_D) || (state_q == RAM_I);
  assign bus.bus_err = bus_err_q;

  coherence_bus_ctrl_rr_arbiter2 u_arb_d (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.dREN | bus.dWEN),
    .advance_i (d_adv),
    .done_id_i (g_q),
    .gnt_id_o  (d_gnt),
    .gnt_vld_o (d_vld)
  );

  coherence_bus_ctrl_rr_arbiter2 u_arb_i (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.iREN),
    .advance_i (i_adv),
    .done_id_i (g_q),
    .gnt_id_o  (i_gnt),
    .gnt_vld_o (i_vld)
  );

  always_comb begin
    state_d         = state_q;
    g_d             = g_q;
    word_d          = word_q;
    cnt_d           = cnt_q;
    d_adv           = 1'b0;
    i_adv           = 1'b0;
    bus.iwait       = 2'b11;
    bus.dwait       = 2'b11;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ccwait      = 2'b00;
    bus.ccinv       = 2'b00;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;

    // Timeout: count non-completing RAM cycles, saturating; never aborts.
    if (ram_phase && !acc && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + 1'b1;
    end
    bus_err_d = bus_err_q |
                (ram_phase && !acc && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)));

    case (state_q)
      IDLE: begin
        word_d = 1'b0;
        if (d_vld) begin
          g_d = d_gnt;
          // Write wins when a core raises dWEN and dREN together.
          if (bus.dWEN[d_gnt]) begin
            state_d = RAM_D;
          end else if (block_first(bus.daddr[d_gnt])) begin
            state_d = SNOOP;
          end else begin
            state_d = RAM_D;
          end
        end else if (i_vld) begin
          g_d     = i_gnt;
          state_d = RAM_I;
        end
      end

      SNOOP: begin
        bus.ccwait[peer]      = 1'b1;
        bus.ccsnoopaddr[peer] = bus.daddr[g_q];
        bus.ccinv[peer]       = bus.ccwrite[g_q];
        word_d                = 1'b0;
        if (!bus.dREN[g_q]) begin
          state_d = IDLE;
        end else if (bus.cctrans[peer]) begin
          // Peer writing back in the answer cycle means it holds the line dirty.
          state_d = bus.dWEN[peer] ? C2C : RAM_D;
        end
      end

      C2C: begin
        // Peer's writeback goes to RAM and is forwarded to the requester.
        bus.ccwait[peer] = 1'b1;
        bus.ramWEN       = bus.dREN[g_q];
        bus.ramaddr      = bus.daddr[peer];
        bus.ramstore     = bus.dstore[peer];
        bus.dload[g_q]   = bus.dstore[peer];
        if (!bus.dREN[g_q]) begin
          state_d = IDLE;
        end else if (acc) begin
          bus.dwait[g_q]  = 1'b0;
          bus.dwait[peer] = 1'b0;
          cnt_d           = '0;
          word_d          = ~word_q;
          if (word_q) begin
            state_d = IDLE;
            d_adv   = 1'b1;
          end
        end
      end

      RAM_D: begin
        bus.ramWEN     = bus.dWEN[g_q];
        bus.ramREN     = bus.dREN[g_q] & ~bus.dWEN[g_q];
        bus.ramaddr    = bus.daddr[g_q];
        bus.ramstore   = bus.dstore[g_q];
        bus.dload[g_q] = bus.ramload;
        if (!(bus.dREN[g_q] | bus.dWEN[g_q])) begin
          state_d = IDLE;
        end else if (acc) begin
          bus.dwait[g_q] = 1'b0;
          state_d        = IDLE;
          d_adv          = 1'b1;
        end
      end

      RAM_I: begin
        bus.ramREN     = bus.iREN[g_q];
        bus.ramaddr    = bus.iaddr[g_q];
        bus.iload[g_q] = bus.ramload;
        if (!bus.iREN[g_q]) begin
          state_d = IDLE;
        end else if (acc) begin
          bus.iwait[g_q] = 1'b0;
          state_d        = IDLE;
          i_adv          = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      g_q       <= 1'b0;
      word_q    <= 1'b0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_coherence_bus_ctrl
// Description : Directed self-checking bench for coherence_bus_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  coherence_bus_ctrl_if bus ();

  coherence_bus_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic word_t ram_fn(input word_t a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // RAM content model: data is a fixed function of the address
  always_comb bus.ramload = ram_fn(bus.ramaddr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic clear_inputs();
    bus.iREN     = 2'b00;
    bus.dREN     = 2'b00;
    bus.dWEN     = 2'b00;
    bus.ccwrite  = 2'b00;
    bus.cctrans  = 2'b00;
    bus.ramstate = FREE;
  endtask

  initial begin
    clear_inputs();
    bus.iaddr  = '0;
    bus.daddr  = '0;
    bus.dstore = '0;

    // Reset state
    @(negedge clk);
    check("rst_iwait", 32'(bus.iwait), 32'h3);
    check("rst_dwait", 32'(bus.dwait), 32'h3);
    check("rst_ramREN", 32'(bus.ramREN), 32'h0);
    check("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("rst_ccwait", 32'(bus.ccwait), 32'h0);
    check("rst_ramaddr", bus.ramaddr, 32'h0);
    check("rst_bus_err", 32'(bus.bus_err), 32'h0);
    rst = 1'b0;
    tick();

    // 1. both icaches, two RAM cycles per access
    bus.iREN = 2'b11; bus.iaddr[0] = 32'h200; bus.iaddr[1] = 32'h300;
    bus.ramstate = BUSY;
    tick();
    check("t1_ramREN", 32'(bus.ramREN), 32'h1);
    check("t1_addr0", bus.ramaddr, 32'h200);
    check("t1_iwait_busy", 32'(bus.iwait), 32'h3);
    tick();
    bus.ramstate = ACCESS; #1;
    check("t1_iwait0", 32'(bus.iwait), 32'h2);
    check("t1_iload0", bus.iload[0], 32'h0200_FDFF);
    tick();
    bus.iREN = 2'b10; bus.ramstate = BUSY; #1;
    check("t1_idle_iwait", 32'(bus.iwait), 32'h3);
    tick();
    check("t1_addr1", bus.ramaddr, 32'h300);
    tick();
    bus.ramstate = ACCESS; #1;
    check("t1_iwait1", 32'(bus.iwait), 32'h1);
    check("t1_iload1", bus.iload[1], 32'h0300_FCFF);
    tick();
    clear_inputs();
    tick();

    // 2. dcache beats icache of the same core
    bus.dREN = 2'b01; bus.daddr[0] = 32'h44;
    bus.iREN = 2'b01; bus.iaddr[0] = 32'h80;
    tick();
    check("t2_ramaddr_d", bus.ramaddr, 32'h44);
    check("t2_ramREN", 32'(bus.ramREN), 32'h1);
    bus.ramstate = ACCESS; #1;
    check("t2_dwait", 32'(bus.dwait), 32'h2);
    check("t2_dload0", bus.dload[0], 32'h0044_FFBB);
    check("t2_iwait_held", 32'(bus.iwait), 32'h3);
    tick();
    bus.dREN = 2'b00;
    tick();
    check("t2_iwait0", 32'(bus.iwait), 32'h2);
    check("t2_iload0", bus.iload[0], 32'h0080_FF7F);
    tick();
    clear_inputs();
    tick();

    // 3. core 1 fill served cache-to-cache by dirty core 0
    bus.dREN = 2'b10; bus.daddr[1] = 32'h100; bus.ccwrite = 2'b00;
    tick();
    check("t3_ccwait", 32'(bus.ccwait), 32'h1);
    check("t3_snoopaddr", bus.ccsnoopaddr[0], 32'h100);
    check("t3_ccinv", 32'(bus.ccinv), 32'h0);
    check("t3_snoop_dwait", 32'(bus.dwait), 32'h3);
    bus.cctrans = 2'b01; bus.dWEN = 2'b01;
    bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hDEADBEEF;
    tick();
    bus.cctrans = 2'b00; #1;
    check("t3_ramWEN", 32'(bus.ramWEN), 32'h1);
    check("t3_addr_w0", bus.ramaddr, 32'h100);
    check("t3_store_w0", bus.ramstore, 32'hDEADBEEF);
    check("t3_c2c_ccwait", 32'(bus.ccwait), 32'h1);
    check("t3_c2c_wait", 32'(bus.dwait), 32'h3);
    bus.ramstate = ACCESS; #1;
    check("t3_dwait_w0", 32'(bus.dwait), 32'h0);
    check("t3_dload_w0", bus.dload[1], 32'hDEADBEEF);
    tick();
    bus.daddr[0] = 32'h104; bus.daddr[1] = 32'h104; bus.dstore[0] = 32'hCAFEF00D; #1;
    check("t3_addr_w1", bus.ramaddr, 32'h104);
    check("t3_dload_w1", bus.dload[1], 32'hCAFEF00D);
    check("t3_dwait_w1", 32'(bus.dwait), 32'h0);
    tick();
    clear_inputs(); #1;
    check("t3_idle_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("t3_idle_ccwait", 32'(bus.ccwait), 32'h0);
    tick();

    // 4. clean peer: RAM read after snoop, ccinv mirrors ccwrite
    bus.dREN = 2'b01; bus.daddr[0] = 32'h180; bus.ccwrite = 2'b01;
    tick();
    check("t4_ccwait", 32'(bus.ccwait), 32'h2);
    check("t4_ccinv_a", 32'(bus.ccinv), 32'h2);
    check("t4_snoopaddr", bus.ccsnoopaddr[1], 32'h180);
    tick();
    check("t4_ccinv_b", 32'(bus.ccinv), 32'h2);
    check("t4_no_ram", 32'(bus.ramREN), 32'h0);
    bus.cctrans = 2'b10; #1;
    check("t4_ccinv_c", 32'(bus.ccinv), 32'h2);
    tick();
    bus.cctrans = 2'b00; #1;
    check("t4_ramREN", 32'(bus.ramREN), 32'h1);
    check("t4_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("t4_ramaddr", bus.ramaddr, 32'h180);
    check("t4_ccwait_off", 32'(bus.ccwait), 32'h0);
    bus.ramstate = ACCESS; #1;
    check("t4_dwait", 32'(bus.dwait), 32'h2);
    check("t4_dload0", bus.dload[0], 32'h0180_FE7F);
    tick();
    clear_inputs();
    tick();

    // 5. RAM BUSY for the whole timeout window
    bus.dREN = 2'b01; bus.daddr[0] = 32'h24; bus.ramstate = BUSY;
    tick();
    tick(63);
    check("t5_err_63", 32'(bus.bus_err), 32'h0);
    tick();
    check("t5_err_64", 32'(bus.bus_err), 32'h1);
    check("t5_still_req", 32'(bus.ramREN), 32'h1);
    bus.ramstate = ACCESS; #1;
    check("t5_dwait", 32'(bus.dwait), 32'h2);
    tick();
    clear_inputs(); #1;
    check("t5_err_sticky", 32'(bus.bus_err), 32'h1);
    tick();

    // Granted request withdrawn before ACCESS: no ack
    bus.dREN = 2'b10; bus.daddr[1] = 32'h1C; bus.ramstate = BUSY;
    tick();
    check("wd_ramaddr", bus.ramaddr, 32'h1C);
    bus.dREN = 2'b00; #1;
    check("wd_ramREN_drop", 32'(bus.ramREN), 32'h0);
    tick();
    bus.ramstate = ACCESS; #1;
    check("wd_no_ack", 32'(bus.dwait), 32'h3);
    clear_inputs();
    tick();

    // 6. reset during C2C
    bus.dREN = 2'b01; bus.daddr[0] = 32'h240; bus.ramstate = BUSY;
    tick();
    bus.cctrans = 2'b10; bus.dWEN = 2'b10;
    bus.daddr[1] = 32'h240; bus.dstore[1] = 32'h12345678;
    tick();
    check("t6_c2c_ramWEN", 32'(bus.ramWEN), 32'h1);
    check("t6_c2c_store", bus.ramstore, 32'h12345678);
    rst = 1'b1; #1;
    check("t6_rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("t6_rst_dwait", 32'(bus.dwait), 32'h3);
    check("t6_rst_iwait", 32'(bus.iwait), 32'h3);
    check("t6_rst_err", 32'(bus.bus_err), 32'h0);
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    check("t6_idle_ccwait", 32'(bus.ccwait), 32'h0);
    check("t6_idle_ramWEN", 32'(bus.ramWEN), 32'h0);
    check("t6_idle_dwait", 32'(bus.dwait), 32'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
